// File: rtl/arith_pkg.sv
// Shared constants for the bit-serial arithmetic blocks: FSM encoding,
// default operand width and the matching bit-counter width.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // One spare bit so the counter can represent WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for serial_subtractor; the master requests,
// the slave (the subtractor) computes and reports.
interface serial_subtractor_if
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, zero
    );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell walks the operands
// LSB first, with the borrow carried between cycles in a flop.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [CW-1:0]    cnt_reg;
    logic             br_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             bout_reg;
    logic             zero_reg;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    full_subtractor u_fs (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .bin  (br_reg),
        .d    (d_bit),
        .bout (br_next)
    );

    // Result bits enter at the MSB so after WIDTH shifts the LSB sits at bit 0.
    assign res_next = {d_bit, res_reg[WIDTH-1:1]};
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            diff_reg  <= '0;
            cnt_reg   <= '0;
            br_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            bout_reg  <= 1'b0;
            zero_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        a_sh_reg  <= bus.a;
                        b_sh_reg  <= bus.b;
                        res_reg   <= '0;
                        cnt_reg   <= '0;
                        br_reg    <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_sh_reg <= a_sh_reg >> 1;
                    b_sh_reg <= b_sh_reg >> 1;
                    res_reg  <= res_next;
                    br_reg   <= br_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    // Visible outputs update only here, so they stay stable through RUN.
                    if (last_bit) begin
                        diff_reg  <= res_next;
                        bout_reg  <= br_next;
                        zero_reg  <= ~|res_next;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.diff = diff_reg;
    assign bus.bout = bout_reg;
    assign bus.zero = zero_reg;

endmodule
